// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, frame-length encodings and defaults.
// The BREAK/MARK states exist only when UART_TX_BREAK_EN is defined.
package uart_pkg;

  localparam int unsigned OVERSAMPLE_DEF = 16;

  localparam logic [1:0] FLEN_5 = 2'b00;
  localparam logic [1:0] FLEN_6 = 2'b01;
  localparam logic [1:0] FLEN_7 = 2'b10;
  localparam logic [1:0] FLEN_8 = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
`ifdef UART_TX_BREAK_EN
    ,
    BREAK,
    MARK
`endif
  } state_e;

  typedef struct packed {
    logic       parity_en;
    logic       parity_odd;
    logic       stop_2;
    logic [1:0] frame_len;
  } frame_cfg_t;

  // Number of data bits carried by a frame_len code.
  function automatic logic [3:0] frame_bits(input logic [1:0] flen);
    logic [3:0] n;
    case (flen)
      FLEN_5:  n = 4'd5;
      FLEN_6:  n = 4'd6;
      FLEN_7:  n = 4'd7;
      default: n = 4'd8;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Sub-bit counter: counts clk_16bd cycles while enabled and strobes on the
// last cycle of each bit time. Held at zero while disabled.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic clk_16bd,
  input  logic rst,
  input  logic i_en,
  output logic o_bit_done_c
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);

  logic [CNT_W-1:0] r_cnt;

  // Power-of-two OVERSAMPLE lets the counter wrap to 0 at each bit boundary.
  always_ff @(posedge clk_16bd or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (!i_en) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_bit_done_c = i_en && (r_cnt == CNT_W'(OVERSAMPLE - 1));

endmodule

// File: rtl/uart_tx_16x.sv
// UART transmitter, 16x bit clock: start, 5-8 data bits LSB first, optional
// parity, 1 or 2 stop bits. Define UART_TX_BREAK_EN to add the brk input.
module uart_tx_16x
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int unsigned DATA_W     = 8
) (
  input  logic              clk_16bd,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  output logic              ready,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              stop_2,
  input  logic [1:0]        frame_len,
`ifdef UART_TX_BREAK_EN
  input  logic              brk,
`endif
  output logic              Tx,
  output logic              busy
);

  state_e            r_state;
  state_e            w_next_state;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_d;
  logic [DATA_W-1:0] w_mask;
  logic [2:0]        r_bit_idx;
  logic [2:0]        w_bit_idx_d;
  logic [2:0]        r_last_idx;
  logic [3:0]        w_nbits;
  frame_cfg_t        r_cfg;
  logic              r_parity_bit;
  logic              w_load;
  logic              w_timer_en;
  logic              w_bit_done;
  logic              w_tx_d;
  logic              w_ready_d;
  logic              w_busy_d;
  logic              r_tx;
  logic              r_ready;
  logic              r_busy;

  uart_bit_timer #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_bit_timer (
    .clk_16bd     (clk_16bd),
    .rst          (rst),
    .i_en         (w_timer_en),
    .o_bit_done_c (w_bit_done)
  );

  // Selects the data bits that belong to the requested frame length.
  always_comb begin
    w_nbits = frame_bits(frame_len);
    w_mask  = '0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      if (i < int'(w_nbits)) begin
        w_mask[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_16bd or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state, datapath updates and the line level for the current state.
  always_comb begin
    w_next_state = r_state;
    w_shift_d    = r_shift;
    w_bit_idx_d  = r_bit_idx;
    w_load       = 1'b0;
    w_timer_en   = 1'b0;
    w_tx_d       = 1'b1;
    case (r_state)
      IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (brk) begin
          w_next_state = BREAK;
        end else
`endif
        if (valid && r_ready) begin
          w_next_state = START;
          w_load       = 1'b1;
          w_shift_d    = data;
          w_bit_idx_d  = 3'd0;
        end
      end
      START: begin
        w_tx_d     = 1'b0;
        w_timer_en = 1'b1;
        if (w_bit_done) begin
          w_next_state = DATA;
        end
      end
      DATA: begin
        w_tx_d     = r_shift[0];
        w_timer_en = 1'b1;
        if (w_bit_done) begin
          w_shift_d = r_shift >> 1;
          if (r_bit_idx == r_last_idx) begin
            w_bit_idx_d  = 3'd0;
            w_next_state = r_cfg.parity_en ? PARITY : STOP;
          end else begin
            w_bit_idx_d = r_bit_idx + 3'd1;
          end
        end
      end
      PARITY: begin
        w_tx_d     = r_parity_bit;
        w_timer_en = 1'b1;
        if (w_bit_done) begin
          w_next_state = STOP;
        end
      end
      STOP: begin
        w_tx_d     = 1'b1;
        w_timer_en = 1'b1;
        if (w_bit_done) begin
          if (r_bit_idx == {2'b00, r_cfg.stop_2}) begin
            w_bit_idx_d  = 3'd0;
            w_next_state = IDLE;
          end else begin
            w_bit_idx_d = r_bit_idx + 3'd1;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      BREAK: begin
        w_tx_d = 1'b0;
        if (!brk) begin
          w_next_state = MARK;
        end
      end
      MARK: begin
        w_tx_d     = 1'b1;
        w_timer_en = 1'b1;
        if (w_bit_done) begin
          w_next_state = IDLE;
        end
      end
`endif
      default: begin
        w_next_state = IDLE;
      end
    endcase
    w_ready_d = (w_next_state == IDLE);
    w_busy_d  = (w_next_state == START) || (w_next_state == DATA) ||
                (w_next_state == PARITY) || (w_next_state == STOP);
  end

  // Frame configuration and parity are captured at the handshake only.
  always_ff @(posedge clk_16bd or negedge rst) begin
    if (!rst) begin
      r_shift      <= '0;
      r_bit_idx    <= 3'd0;
      r_last_idx   <= 3'd0;
      r_cfg        <= '0;
      r_parity_bit <= 1'b0;
      r_tx         <= 1'b1;
      r_ready      <= 1'b1;
      r_busy       <= 1'b0;
    end else begin
      r_shift   <= w_shift_d;
      r_bit_idx <= w_bit_idx_d;
      r_tx      <= w_tx_d;
      r_ready   <= w_ready_d;
      r_busy    <= w_busy_d;
      if (w_load) begin
        r_last_idx   <= 3'(w_nbits - 4'd1);
        r_cfg        <= '{parity_en:  parity_en,
                          parity_odd: parity_odd,
                          stop_2:     stop_2,
                          frame_len:  frame_len};
        r_parity_bit <= (^(data & w_mask)) ^ parity_odd;
      end
    end
  end

  assign Tx    = r_tx;
  assign ready = r_ready;
  assign busy  = r_busy;

endmodule

// File: tb/tb_uart_tx_16x.sv
// Directed self-checking bench for uart_tx_16x (8N1, 7E1, 5O2, back-to-back,
// mid-frame reset, and the break sequence when UART_TX_BREAK_EN is defined).
module tb_uart_tx_16x;

  logic       clk_16bd = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       parity_en;
  logic       parity_odd;
  logic       stop_2;
  logic [1:0] frame_len;
  logic       Tx;
  logic       busy;
`ifdef UART_TX_BREAK_EN
  logic       brk;
`endif

  int total = 0;
  int bad   = 0;

  uart_tx_16x #(
    .OVERSAMPLE (16),
    .DATA_W     (8)
  ) dut (
    .clk_16bd   (clk_16bd),
    .rst        (rst),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .stop_2     (stop_2),
    .frame_len  (frame_len),
`ifdef UART_TX_BREAK_EN
    .brk        (brk),
`endif
    .Tx         (Tx),
    .busy       (busy)
  );

  always #5 clk_16bd = ~clk_16bd;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_8n1();
    frame_len  = 2'b11;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    stop_2     = 1'b0;
  endtask

  // Called at a negedge with valid already high; the next posedge is the
  // transfer. lv lists the line level of each bit time, start bit first.
  task automatic expect_frame(input string tag, input string lv, input bit hold,
                              input bit disturb, input logic [7:0] nxt);
    int nc;
    logic exp_tx;
    nc = 16 * lv.len();
    chk({tag, " pre_ready"}, 32'(ready), 32'd1);
    @(negedge clk_16bd);
    if (!hold) valid = 1'b0;
    chk({tag, " latency_tx"}, 32'(Tx), 32'd1);
    chk({tag, " accept_ready"}, 32'(ready), 32'd0);
    chk({tag, " accept_busy"}, 32'(busy), 32'd1);
    for (int k = 1; k <= nc; k++) begin
      if (disturb && k == 40) begin
        data       = nxt;
        frame_len  = 2'b00;
        parity_en  = 1'b1;
        parity_odd = 1'b1;
        stop_2     = 1'b1;
      end
      if (disturb && k == 120) cfg_8n1();
      @(negedge clk_16bd);
      exp_tx = (lv[(k - 1) / 16] == "1");
      chk({tag, " tx"}, 32'(Tx), 32'(exp_tx));
      chk({tag, " ready"}, 32'(ready), 32'(k == nc));
    end
    chk({tag, " end_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst   = 1'b0;
    valid = 1'b0;
    data  = 8'h00;
    cfg_8n1();
`ifdef UART_TX_BREAK_EN
    brk = 1'b0;
`endif
    repeat (3) @(negedge clk_16bd);
    chk("reset tx", 32'(Tx), 32'd1);
    chk("reset ready", 32'(ready), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk_16bd);

    // Line stays marking while nothing is offered.
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_16bd);
      chk("idle tx", 32'(Tx), 32'd1);
      chk("idle ready", 32'(ready), 32'd1);
    end

    data = 8'hA5; valid = 1'b1;
    expect_frame("8N1_A5", "0101001011", 1'b0, 1'b0, 8'h00);
    @(negedge clk_16bd);
    chk("8N1_A5 post_tx", 32'(Tx), 32'd1);

    frame_len = 2'b10; parity_en = 1'b1; parity_odd = 1'b0; stop_2 = 1'b0;
    data = 8'hC1; valid = 1'b1;
    expect_frame("7E1_C1", "0100000101", 1'b0, 1'b0, 8'h00);
    @(negedge clk_16bd);

    frame_len = 2'b00; parity_en = 1'b1; parity_odd = 1'b1; stop_2 = 1'b1;
    data = 8'h1F; valid = 1'b1;
    expect_frame("5O2_1F", "011111011", 1'b0, 1'b0, 8'h00);
    @(negedge clk_16bd);

    // valid held across both frames; inputs disturbed during the first.
    cfg_8n1();
    data = 8'h55; valid = 1'b1;
    expect_frame("b2b_55", "0101010101", 1'b1, 1'b1, 8'hAA);
    expect_frame("b2b_AA", "0010101011", 1'b0, 1'b0, 8'h00);
    @(negedge clk_16bd);

    // Reset 50 cycles into a frame of zeros.
    data = 8'h00; valid = 1'b1;
    @(negedge clk_16bd);
    valid = 1'b0;
    repeat (49) @(negedge clk_16bd);
    chk("midrst pre_tx", 32'(Tx), 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst tx", 32'(Tx), 32'd1);
    chk("midrst ready", 32'(ready), 32'd1);
    chk("midrst busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk_16bd);
    chk("midrst held_tx", 32'(Tx), 32'd1);
    rst = 1'b1;
    @(negedge clk_16bd);
    data = 8'h3C; valid = 1'b1;
    expect_frame("rst_3C", "0001111001", 1'b0, 1'b0, 8'h00);
    @(negedge clk_16bd);

`ifdef UART_TX_BREAK_EN
    // brk beats a simultaneous valid; 300 cycles of space, then 16 of mark.
    data = 8'h12; valid = 1'b1; brk = 1'b1;
    @(negedge clk_16bd);
    chk("brk latency_tx", 32'(Tx), 32'd1);
    chk("brk ready", 32'(ready), 32'd0);
    for (int k = 1; k <= 316; k++) begin
      if (k == 300) brk = 1'b0;
      if (k == 310) valid = 1'b0;
      @(negedge clk_16bd);
      chk("brk tx", 32'(Tx), 32'(k > 300));
      chk("brk ready", 32'(ready), 32'(k == 316));
      chk("brk busy", 32'(busy), 32'd0);
    end
    repeat (20) @(negedge clk_16bd);
    chk("brk after_tx", 32'(Tx), 32'd1);
    chk("brk after_ready", 32'(ready), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
